// File: rtl/mult_pkg.sv
// Shared types and constants for the 16x16 sequential multiplier.
// Signed correction built only when SEQ_MULT_SIGNED_EN is defined.
package mult_pkg;

  localparam int N          = 16;
  localparam int CNT_W      = 5;
  localparam int MULT_LAT_U = 16;
  localparam int MULT_LAT_S = 18;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    CORR_A,
    CORR_B,
    DONE
  } state_t;

endpackage

// File: rtl/seq_mult_16b_if.sv
// Ready/valid operand and product bundle for seq_mult_16b.
// master drives operands and accepts products; slave is the multiplier.
interface seq_mult_16b_if;
  import mult_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     a;
  logic [N-1:0]     b;
  logic             signed_op;
  logic             out_valid;
  logic             out_ready;
  logic [2*N-1:0]   product;

  modport master (
    output in_valid, a, b, signed_op, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, a, b, signed_op, out_ready,
    output in_ready, out_valid, product
  );

endinterface

// File: rtl/carryLA_16b.sv
// 16-bit carry-lookahead adder, four 4-bit groups.
// Group carries come from group generate/propagate terms.
module carryLA_16b (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        CI,
  output logic [15:0] SUM,
  output logic        CO,
  output logic        Ofl
);

  logic [15:0] p;
  logic [15:0] g;
  logic [16:0] c;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  gc;

  assign p = A ^ B;
  assign g = A & B;

  // group generate/propagate, lookahead group carries, bit carries
  always_comb begin
    gg = '0;
    gp = '0;
    gc = '0;
    c  = '0;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
    gc[0] = CI;
    for (int k = 0; k < 4; k++)
      gc[k+1] = gg[k] | (gp[k] & gc[k]);
    for (int k = 0; k < 4; k++) begin
      c[4*k] = gc[k];
      for (int j = 0; j < 3; j++)
        c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
    end
    c[16] = gc[4];
  end

  assign SUM = p ^ c[15:0];
  assign CO  = c[16];
  assign Ofl = c[16] ^ c[15];

endmodule

// File: rtl/seq_mult_16b.sv
// Iterative shift-add 16x16 multiplier on one shared CLA adder.
// SEQ_MULT_SIGNED_EN adds two two's-complement correction cycles.
module seq_mult_16b
  import mult_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  seq_mult_16b_if.slave  io
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  state_t           state;
  logic [N-1:0]     hi;
  logic [N-1:0]     lo;
  logic [N-1:0]     mcand;
  logic [CNT_W-1:0] cnt;
  logic             in_rdy;
  logic             out_vld;

  logic [N-1:0]     add_a;
  logic [N-1:0]     add_b;
  logic             add_ci;
  logic [N-1:0]     sum;
  logic             co;
  logic             ofl_unused;

`ifdef SEQ_MULT_SIGNED_EN
  logic [N-1:0]     mcand_b;
  logic             sop;
`else
  logic             sop_unused;
  assign sop_unused = io.signed_op;
`endif

  assign io.in_ready  = in_rdy;
  assign io.out_valid = out_vld;
  assign io.product   = {hi, lo};

  // adder operand mux: partial product in RUN, subtraction in CORR
  always_comb begin
    add_a  = hi;
    add_b  = lo[0] ? mcand : '0;
    add_ci = 1'b0;
    case (state)
`ifdef SEQ_MULT_SIGNED_EN
      CORR_A: begin
        add_b  = ~(mcand[N-1] ? mcand_b : '0);
        add_ci = 1'b1;
      end
      CORR_B: begin
        add_b  = ~(mcand_b[N-1] ? mcand : '0);
        add_ci = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  carryLA_16b u_cla (
    .A   (add_a),
    .B   (add_b),
    .CI  (add_ci),
    .SUM (sum),
    .CO  (co),
    .Ofl (ofl_unused)
  );

  // control FSM with datapath registers and registered handshakes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      hi      <= '0;
      lo      <= '0;
      mcand   <= '0;
      cnt     <= '0;
      in_rdy  <= 1'b0;
      out_vld <= 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
      mcand_b <= '0;
      sop     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (io.in_valid && in_rdy) begin
            mcand  <= io.a;
            lo     <= io.b;
            hi     <= '0;
            cnt    <= '0;
            in_rdy <= 1'b0;
            state  <= RUN;
`ifdef SEQ_MULT_SIGNED_EN
            mcand_b <= io.b;
            sop     <= io.signed_op;
`endif
          end else begin
            in_rdy <= 1'b1;
          end
        end
        RUN: begin
          {hi, lo} <= {co, sum, lo[N-1:1]};
          cnt      <= cnt + 1'b1;
          if (cnt == LAST) begin
`ifdef SEQ_MULT_SIGNED_EN
            if (sop) begin
              state <= CORR_A;
            end else begin
              state   <= DONE;
              out_vld <= 1'b1;
            end
`else
            state   <= DONE;
            out_vld <= 1'b1;
`endif
          end
        end
`ifdef SEQ_MULT_SIGNED_EN
        CORR_A: begin
          hi    <= sum;
          state <= CORR_B;
        end
        CORR_B: begin
          hi      <= sum;
          state   <= DONE;
          out_vld <= 1'b1;
        end
`endif
        DONE: begin
          if (io.out_ready) begin
            out_vld <= 1'b0;
            in_rdy  <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
